// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait-state counter width and the address-error test.
`ifndef DMEM_RESPONDER_PKG_SV
`define DMEM_RESPONDER_PKG_SV

// Address error: the address is not word aligned, or it has bits set above
// the last stored word. The arguments are an address vector, its width and
// log2 of the number of words.
`define DMEM_ADDR_ERR(addr, aw, depth) \
  (((addr[1:0]) != 2'b00) || ((addr[(aw)-1:(depth)+2]) != '0))

package dmem_responder_pkg;

  // Responder FSM states. The encodings are fixed so that waveform and
  // debug tooling can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Width of the wait-state counter. LATENCY is limited to 0..15 so that
  // LATENCY-1 always fits.
  localparam int CNT_W   = 4;
  localparam int LAT_MAX = 15;

endpackage

`endif

// File: rtl/dmem_array.sv
// Word storage for the responder: 2^DEPTH words of DWIDTH bits.
// Writes are synchronous, with one write enable per byte lane.
// Reads are combinational by word index.
module dmem_array #(
  parameter int DWIDTH  = 32,
  parameter int DEPTH   = 6,
  parameter int BEWIDTH = DWIDTH / 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [BEWIDTH-1:0] be_i,
  input  logic [DEPTH-1:0]   idx_i,
  input  logic [DWIDTH-1:0]  wdata_i,
  output logic [DWIDTH-1:0]  rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**DEPTH];

  // Byte-lane write. Lanes whose enable is clear keep their old contents.
  // NOTE: the storage has no reset. Clearing it would need a per-word reset
  // network, and nothing here depends on its initial contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BEWIDTH; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: the memory side of the processor load/store port.
// It takes one request at a time, waits LATENCY cycles, then commits the
// request to storage. On the following cycle it raises a one-cycle ack with
// the read data, or with an error for a misaligned or out-of-range address.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int DEPTH      = 6,
  parameter int LATENCY    = 2,
  parameter int BEWIDTH    = DWIDTH / 8
) (
  input  logic                  m_clk,
  input  logic                  m_rst,
  input  logic                  m_i_ce,
  input  logic                  m_i_req,
  input  logic                  m_i_we,
  input  logic [AWIDTH_MEM-1:0] m_i_addr,
  input  logic [DWIDTH-1:0]     m_i_wdata,
  input  logic [BEWIDTH-1:0]    m_i_be,
  output logic                  m_o_busy,
  output logic                  m_o_ack,
  output logic                  m_o_err,
  output logic [DWIDTH-1:0]     m_o_rdata
);

  // Value loaded into the wait counter on accept. When LATENCY is 0 the
  // counter is never used.
  localparam logic [CNT_W-1:0] LAT_LOAD =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   we_q;
  logic [AWIDTH_MEM-1:0]  addr_q;
  logic [DWIDTH-1:0]      wdata_q;
  logic [BEWIDTH-1:0]     be_q;
  logic                   ack_q;
  logic                   err_q;
  logic [DWIDTH-1:0]      rdata_q;

  logic                   accept;
  logic                   commit;
  logic                   cm_we;
  logic [AWIDTH_MEM-1:0]  cm_addr;
  logic [DWIDTH-1:0]      cm_wdata;
  logic [BEWIDTH-1:0]     cm_be;
  logic                   cm_err;
  logic                   arr_we;
  logic [DWIDTH-1:0]      arr_rdata;

  // Chip enable gates only new requests. A transaction that is already in
  // flight always runs to completion.
  assign accept = (state_q == ST_IDLE) && m_i_ce && m_i_req;

  // Select the request being committed. With zero wait states the commit
  // happens on the accept edge itself, so the live inputs are used directly.
  // Otherwise the copy latched on accept is used.
  always_comb begin
    if (LATENCY == 0) begin
      commit   = accept;
      cm_we    = m_i_we;
      cm_addr  = m_i_addr;
      cm_wdata = m_i_wdata;
      cm_be    = m_i_be;
    end else begin
      commit   = (state_q == ST_WAIT) && (cnt_q == '0);
      cm_we    = we_q;
      cm_addr  = addr_q;
      cm_wdata = wdata_q;
      cm_be    = be_q;
    end
  end

  assign cm_err = `DMEM_ADDR_ERR(cm_addr, AWIDTH_MEM, DEPTH);
  assign arr_we = commit && cm_we && !cm_err;

  dmem_array #(
    .DWIDTH  (DWIDTH),
    .DEPTH   (DEPTH),
    .BEWIDTH (BEWIDTH)
  ) u_array (
    .clk     (m_clk),
    .we_i    (arr_we),
    .be_i    (cm_be),
    .idx_i   (cm_addr[DEPTH+1:2]),
    .wdata_i (cm_wdata),
    .rdata_o (arr_rdata)
  );

  // FSM state register.
  // NOTE: all clocked state uses non-blocking assignments. Every register
  // then samples values from before the edge, whatever order the blocks
  // evaluate in.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  // NOTE: state_d takes a default before the case statement. Every path
  // then assigns it, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers the whole time a transaction is in flight.
  always_comb begin
    m_o_busy = (state_q != ST_IDLE);
  end

  // Wait-state counter and request capture on accept.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      cnt_q   <= LAT_LOAD;
      we_q    <= m_i_we;
      addr_q  <= m_i_addr;
      wdata_q <= m_i_wdata;
      be_q    <= m_i_be;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Response registers. They are loaded on the commit edge and hold their
  // value for exactly the RESP cycle. Outside that cycle they read as zero.
  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= commit;
      err_q   <= commit && cm_err;
      rdata_q <= (commit && !cm_we && !cm_err) ? arr_rdata : '0;
    end
  end

  assign m_o_ack   = ack_q;
  assign m_o_err   = err_q;
  assign m_o_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Instance A uses LATENCY=2 and instance B
// uses LATENCY=0. Each stimulus task pushes the expected response into a
// per-instance queue. A monitor for each instance pops that queue and
// compares whenever the instance raises ack.
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic        a_ce = 0, a_req = 0, a_we = 0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_be = '0;
  logic        a_busy, a_ack, a_err;
  logic [31:0] a_rdata;

  logic        b_ce = 0, b_req = 0, b_we = 0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_busy, b_ack, b_err;
  logic [31:0] b_rdata;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DWIDTH(32), .AWIDTH_MEM(32), .DEPTH(6), .LATENCY(LAT_A)) u_dut_a (
    .m_clk(clk), .m_rst(rst_n), .m_i_ce(a_ce), .m_i_req(a_req), .m_i_we(a_we),
    .m_i_addr(a_addr), .m_i_wdata(a_wdata), .m_i_be(a_be),
    .m_o_busy(a_busy), .m_o_ack(a_ack), .m_o_err(a_err), .m_o_rdata(a_rdata)
  );

  dmem_responder #(.DWIDTH(32), .AWIDTH_MEM(32), .DEPTH(6), .LATENCY(LAT_B)) u_dut_b (
    .m_clk(clk), .m_rst(rst_n), .m_i_ce(b_ce), .m_i_req(b_req), .m_i_we(b_we),
    .m_i_addr(b_addr), .m_i_wdata(b_wdata), .m_i_be(b_be),
    .m_o_busy(b_busy), .m_o_ack(b_ack), .m_o_err(b_err), .m_o_rdata(b_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (a_ack) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          check("a_ack_cycle", cyc, e.exp_cyc);
          check("a_err", {31'b0, a_err}, {31'b0, e.err});
          check("a_rdata", a_rdata, e.rdata);
        end
      end else begin
        check("a_idle_err_rdata", a_rdata | {31'b0, a_err}, 32'd0);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (b_ack) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          check("b_ack_cycle", cyc, e.exp_cyc);
          check("b_err", {31'b0, b_err}, {31'b0, e.err});
          check("b_rdata", b_rdata, e.rdata);
        end
      end else begin
        check("b_idle_err_rdata", b_rdata | {31'b0, b_err}, 32'd0);
      end
    end
  end

  task automatic wait_idle(input int dut);
    for (int i = 0; i < 40; i++) begin
      if (((dut == 0) ? a_busy : b_busy) == 1'b0) return;
      @(posedge clk); #1;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one request to an idle instance, push the expected response and
  // wait until the instance is idle again.
  task automatic xact(input int dut, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    @(posedge clk); #1;
    e.err     = exp_err;
    e.rdata   = exp_rdata;
    e.exp_cyc = cyc + 1 + ((dut == 0) ? LAT_A : LAT_B);
    if (dut == 0) begin
      a_ce = 1; a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
      q_a.push_back(e);
    end else begin
      b_ce = 1; b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    if (dut == 0) begin
      a_req = 0;
      check("a_busy_after_accept", {31'b0, a_busy}, 32'd1);
    end else begin
      b_req = 0;
      check("b_busy_after_accept", {31'b0, b_busy}, 32'd1);
    end
    wait_idle(dut);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   c;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_busy", {31'b0, a_busy}, 32'd0);
    check("rst_a_ack_err", {30'b0, a_ack, a_err}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_busy", {31'b0, b_busy}, 32'd0);
    rst_n = 1;

    // Instance A, LATENCY=2.
    xact(0, 1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    xact(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF);
    xact(0, 1, 32'h8, 32'h000000AA, 4'b0001, 0, 32'h0);
    xact(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEAA);
    xact(0, 1, 32'h8, 32'h12345678, 4'b0000, 0, 32'h0);
    xact(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEAA);
    xact(0, 0, 32'h6, 32'h0, 4'h0, 1, 32'h0);
    xact(0, 0, 32'h100, 32'h0, 4'h0, 1, 32'h0);
    xact(0, 1, 32'h0, 32'h01234567, 4'hF, 0, 32'h0);
    xact(0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
    xact(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h01234567);
    xact(0, 0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEAA);

    // Request held high: accepts are LATENCY+2 apart, and the request
    // present in each ack cycle is ignored.
    @(posedge clk); #1;
    c = cyc;
    a_ce = 1; a_req = 1; a_we = 0; a_addr = 32'h8; a_be = 4'h0;
    for (int k = 0; k < 3; k++) begin
      e.err = 0; e.rdata = 32'hDEADBEAA; e.exp_cyc = c + 1 + k * (LAT_A + 2) + LAT_A;
      q_a.push_back(e);
    end
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      check("a_busy_held_req", {31'b0, a_busy}, {31'b0, ((j % 4) != 3)});
    end
    a_req = 0;
    wait_idle(0);

    // Instance B, LATENCY=0, including the last word in range.
    xact(1, 1, 32'h4, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    xact(1, 0, 32'h4, 32'h0, 4'h0, 0, 32'hCAFEF00D);
    xact(1, 1, 32'hFC, 32'h5A5A5A5A, 4'hF, 0, 32'h0);
    xact(1, 0, 32'hFC, 32'h0, 4'h0, 0, 32'h5A5A5A5A);
    xact(1, 0, 32'h4, 32'h0, 4'h0, 0, 32'hCAFEF00D);

    // Chip enable low: the request is never accepted.
    @(posedge clk); #1;
    b_ce = 0; b_req = 1; b_we = 0; b_addr = 32'h4;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("b_busy_ce_low", {31'b0, b_busy}, 32'd0);
    end
    b_req = 0; b_ce = 1;

    // Reset during WAIT of a write drops the transaction.
    xact(0, 1, 32'hC, 32'h11111111, 4'hF, 0, 32'h0);
    @(posedge clk); #1;
    a_ce = 1; a_req = 1; a_we = 1; a_addr = 32'hC; a_wdata = 32'h22222222; a_be = 4'hF;
    @(posedge clk); #1;
    a_req = 0;
    check("a_busy_before_reset", {31'b0, a_busy}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("a_busy_in_reset", {31'b0, a_busy}, 32'd0);
    check("a_ack_err_in_reset", {30'b0, a_ack, a_err}, 32'd0);
    check("a_rdata_in_reset", a_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    xact(0, 0, 32'hC, 32'h0, 4'h0, 0, 32'h11111111);

    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
